// File: rtl/sincos_pkg.sv
// Shared constants and enums for the sincos phase generator.
package sincos_pkg;

    // Width chosen so PI_Q24 stays positive when treated as signed.
    localparam int PI_W = 28;
    localparam logic signed [PI_W-1:0] PI_Q24 = 28'sd52707179;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } gen_state_t;

    typedef enum logic {
        TONE  = 1'b0,
        CHIRP = 1'b1
    } gen_mode_t;

endpackage

// File: rtl/sincos_phase_fold.sv
// Pipeline stages 2 and 3: fold phase into [-pi/2, pi/2], then scale to Q3.24 radians.
module sincos_phase_fold
    import sincos_pkg::*;
#(
    parameter int PHASE_W = 32,
    parameter int ANGLE_W = 27
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_valid,
    input  logic                      i_last,
    input  logic [PHASE_W-1:0]        i_phase,
    output logic                      o_valid,
    output logic                      o_last,
    output logic                      o_cos_neg,
    output logic signed [ANGLE_W-1:0] o_angle,
    output logic                      o_busy
);

    localparam int PROD_W = PHASE_W + PI_W;
    localparam logic [PHASE_W-1:0] HALF_TURN = {1'b1, {(PHASE_W-1){1'b0}}};

    logic                      w_fold;
    logic signed [PHASE_W-1:0] r_a;
    logic                      r_s2_valid;
    logic                      r_s2_last;
    logic                      r_s2_cos_neg;

    // Top two bits 01 or 10 means outside [-quarter, +quarter); -quarter itself (11) stays put.
    assign w_fold = i_phase[PHASE_W-1] ^ i_phase[PHASE_W-2];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_a          <= '0;
            r_s2_valid   <= 1'b0;
            r_s2_last    <= 1'b0;
            r_s2_cos_neg <= 1'b0;
            o_angle      <= '0;
            o_valid      <= 1'b0;
            o_last       <= 1'b0;
            o_cos_neg    <= 1'b0;
        end else begin
            r_a          <= w_fold ? (HALF_TURN - i_phase) : i_phase;
            r_s2_valid   <= i_valid;
            r_s2_last    <= i_last;
            r_s2_cos_neg <= w_fold;
            o_angle      <= ANGLE_W'((PROD_W'(r_a) * PROD_W'(PI_Q24)) >>> (PHASE_W-1));
            o_valid      <= r_s2_valid;
            o_last       <= r_s2_last;
            o_cos_neg    <= r_s2_cos_neg;
        end
    end

    assign o_busy = r_s2_valid | o_valid;

endmodule

// File: rtl/sincos_phase_gen.sv
// NCO front end for the sincos core: config regs, run FSM, phase accumulator, sample counter.
module sincos_phase_gen
    import sincos_pkg::*;
#(
    parameter int PHASE_W = 32,
    parameter int ANGLE_W = 27,
    parameter int CNT_W   = 24
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_cfg_valid,
    output logic                      o_cfg_ready,
    input  logic                      i_cfg_mode,
    input  logic [PHASE_W-1:0]        i_cfg_freq,
    input  logic [PHASE_W-1:0]        i_cfg_step,
    input  logic [PHASE_W-1:0]        i_cfg_limit,
    input  logic [CNT_W-1:0]          i_cfg_count,
    input  logic                      i_start,
    input  logic                      i_stop,
    output logic signed [ANGLE_W-1:0] o_angle,
    output logic                      o_angle_valid,
    output logic                      o_cos_neg,
    output logic                      o_busy,
    output logic                      o_done
);

    gen_state_t         r_state;
    gen_state_t         w_state_next;
    gen_mode_t          r_cfg_mode;
    logic [PHASE_W-1:0] r_cfg_freq;
    logic [PHASE_W-1:0] r_cfg_step;
    logic [PHASE_W-1:0] r_cfg_limit;
    logic [CNT_W-1:0]   r_cfg_count;
    logic [PHASE_W-1:0] r_phase;
    logic [PHASE_W-1:0] r_freq;
    logic [CNT_W-1:0]   r_count;
    logic [PHASE_W-1:0] r_s1_phase;
    logic               r_s1_valid;
    logic               r_s1_last;

    logic               w_cfg_load;
    logic               w_start;
    logic               w_run;
    logic               w_last;
    logic [PHASE_W-1:0] w_freq_sum;
    logic               w_last_out;
    logic               w_valid_out;
    logic               w_fold_busy;

    assign w_run      = (r_state == RUN);
    assign w_cfg_load = (r_state == IDLE) & i_cfg_valid;
    // A config offer wins over a simultaneous start.
    assign w_start    = (r_state == IDLE) & i_start & ~i_cfg_valid;
    assign w_last     = w_run && (r_cfg_count != '0) && (r_count == r_cfg_count - CNT_W'(1));
    assign w_freq_sum = r_freq + r_cfg_step;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_start) w_state_next = RUN;
            RUN:     if (i_stop || w_last) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cfg_mode  <= TONE;
            r_cfg_freq  <= '0;
            r_cfg_step  <= '0;
            r_cfg_limit <= '0;
            r_cfg_count <= '0;
            r_phase     <= '0;
            r_freq      <= '0;
            r_count     <= '0;
            r_s1_phase  <= '0;
            r_s1_valid  <= 1'b0;
            r_s1_last   <= 1'b0;
        end else begin
            if (w_cfg_load) begin
                r_cfg_mode  <= gen_mode_t'(i_cfg_mode);
                r_cfg_freq  <= i_cfg_freq;
                r_cfg_step  <= i_cfg_step;
                r_cfg_limit <= i_cfg_limit;
                r_cfg_count <= i_cfg_count;
            end
            if (w_start) begin
                r_phase <= '0;
                r_freq  <= r_cfg_freq;
                r_count <= '0;
            end else if (w_run) begin
                r_phase <= r_phase + r_freq;
                r_count <= r_count + CNT_W'(1);
                if (r_cfg_mode == CHIRP) begin
                    r_freq <= (w_freq_sum >= r_cfg_limit) ? r_cfg_freq : w_freq_sum;
                end
            end
            r_s1_phase <= r_phase;
            r_s1_valid <= w_run;
            r_s1_last  <= w_last;
        end
    end

    sincos_phase_fold #(
        .PHASE_W (PHASE_W),
        .ANGLE_W (ANGLE_W)
    ) u_fold (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_valid   (r_s1_valid),
        .i_last    (r_s1_last),
        .i_phase   (r_s1_phase),
        .o_valid   (w_valid_out),
        .o_last    (w_last_out),
        .o_cos_neg (o_cos_neg),
        .o_angle   (o_angle),
        .o_busy    (w_fold_busy)
    );

    assign o_angle_valid = w_valid_out;
    assign o_done        = w_valid_out & w_last_out;
    assign o_cfg_ready   = (r_state == IDLE);
    assign o_busy        = w_run | r_s1_valid | w_fold_busy;

endmodule
